alu_mc: RTL

- Parametrised, registered, multi-cycle successor to the 4-bit combinational ALU used in the lab datapath.
- Extends the original eight single-cycle operations with shifts, an iterative shift-add multiply and a restoring unsigned divide/remainder.
- Adds valid/ready handshakes on input and output so it can sit between the decode stage and writeback, stalling upstream while a multi-cycle op runs.

---
 rtl/alu_mc_if.sv | 31 +++
 rtl/alu_mc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: handshake bundle for the multi-cycle ALU.
//   in_valid/in_ready + a, b, ctrl : operand request channel
//   out_valid/out_ready + res, res_hi, car, of, zf, dz : result channel
// master = producer of operands / consumer of results; slave = the ALU.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             car;
  logic             of;
  logic             zf;
  logic             dz;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, res, res_hi, car, of, zf, dz
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, res, res_hi, car, of, zf, dz
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready on both sides.
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_mc_if.slave (operand request in, registered result out)
// Single-cycle ops land in DONE on the accepting edge; MUL/DIVU/REMU run
// WIDTH iterative steps in BUSY, the last step writing the result registers.
module alu_mc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic               accept, in_multi;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [2*WIDTH-1:0] mp_q, mp_d;
  logic [WIDTH-1:0]   dq_q, dq_d, dr_q, dr_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   sc_res, fin_res;
  logic               sc_car, sc_of, sc_dz;
  logic [WIDTH:0]     sum, mul_sum, div_sh, div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   res_q, hi_q;
  logic               car_q, of_q, zf_q, dz_q, ov_q;

  // Accept while idle, or while a result is being drained this cycle.
  assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  // Divide by zero short-circuits to the single-cycle path.
  assign in_multi     = (bus.ctrl == OP_MUL) ||
                        (((bus.ctrl == OP_DIVU) || (bus.ctrl == OP_REMU)) && (bus.b != '0));

  assign bus.out_valid = ov_q;
  assign bus.res       = res_q;
  assign bus.res_hi    = hi_q;
  assign bus.car       = car_q;
  assign bus.of        = of_q;
  assign bus.zf        = zf_q;
  assign bus.dz        = dz_q;

  // Single-cycle result from the live operands.
  always_comb begin
    sc_res = '0;
    sc_car = 1'b0;
    sc_of  = 1'b0;
    sc_dz  = 1'b0;
    sum    = '0;
    case (bus.ctrl)
      OP_ADD: begin
        sum    = {1'b0, bus.a} + {1'b0, bus.b};
        sc_res = sum[WIDTH-1:0];
        sc_car = sum[WIDTH];
        sc_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        sc_res = sum[WIDTH-1:0];
        sc_car = sum[WIDTH];
        sc_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOT:  sc_res = ~bus.a;
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_SLL:  sc_res = bus.a << bus.b[SHW-1:0];
      OP_SRL:  sc_res = bus.a >> bus.b[SHW-1:0];
      OP_SRA:  sc_res = $signed(bus.a) >>> bus.b[SHW-1:0];
      OP_DIVU: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_REMU: begin
        sc_res = bus.a;
        sc_dz  = 1'b1;
      end
      default: sc_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step per cycle.
  always_comb begin
    mul_sum = {1'b0, mp_q[2*WIDTH-1:WIDTH]} + (mp_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    mp_d    = {mul_sum, mp_q[WIDTH-1:1]};
    div_sh  = {dr_q, dq_q[WIDTH-1]};
    div_sub = div_sh - {1'b0, opb_q};
    div_ge  = (div_sh >= {1'b0, opb_q});
    dr_d    = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    dq_d    = {dq_q[WIDTH-2:0], div_ge};
    fin_res = (op_q == OP_MUL)  ? mp_d[WIDTH-1:0] :
              (op_q == OP_DIVU) ? dq_d : dr_d;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = in_multi ? BUSY : DONE;
      BUSY: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = in_multi ? BUSY : DONE;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latches, iteration registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q  <= 1'b0;
      op_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      mp_q  <= '0;
      dq_q  <= '0;
      dr_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
      hi_q  <= '0;
      car_q <= 1'b0;
      of_q  <= 1'b0;
      zf_q  <= 1'b1;
      dz_q  <= 1'b0;
    end else begin
      ov_q <= (state_d == DONE);
      if (accept) begin
        op_q  <= bus.ctrl;
        opa_q <= bus.a;
        opb_q <= bus.b;
        mp_q  <= {{WIDTH{1'b0}}, bus.b};
        dq_q  <= bus.a;
        dr_q  <= '0;
        cnt_q <= CW'(WIDTH);
        if (!in_multi) begin
          res_q <= sc_res;
          hi_q  <= '0;
          car_q <= sc_car;
          of_q  <= sc_of;
          zf_q  <= (sc_res == '0);
          dz_q  <= sc_dz;
        end
      end else if (state_q == BUSY) begin
        mp_q  <= mp_d;
        dq_q  <= dq_d;
        dr_q  <= dr_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_q <= fin_res;
          hi_q  <= (op_q == OP_MUL) ? mp_d[2*WIDTH-1:WIDTH] : '0;
          car_q <= 1'b0;
          of_q  <= 1'b0;
          zf_q  <= (fin_res == '0);
          dz_q  <= 1'b0;
        end
      end
    end
  end
endmodule
